// File: rtl/pll_div_monitor.sv
// pll_div_monitor
//   Measures a slow clock (clkm) against the fast clock clki. It reports the
//   rise-to-rise period and the rise-to-fall high time, both in clki cycles.
//   It raises locked once the period has matched the previous one, within
//   TOL, for LOCK_COUNT consecutive measurements.
// Ports
//   clki      in   measurement clock, all logic on posedge
//   rst       in   asynchronous, active-high reset
//   clkm      in   monitored clock, asynchronous to clki
//   clr       in   synchronous clear: back to SEEK, clears outputs and overflow
//   period    out  last rise-to-rise interval (clki cycles)
//   high_time out  last rise-to-fall interval (0 if no fall was seen)
//   valid     out  one-cycle pulse when period/high_time update
//   locked    out  period stable for LOCK_COUNT consecutive measurements
//   overflow  out  sticky, set when no rise is seen for 2^CNT_W-1 cycles while tracking
//   dbg_state out  current FSM state (SEEK=0, TRACK=1, LOCK=2)
module pll_div_monitor #(
   parameter int CNT_W       = 16,
   parameter int LOCK_COUNT  = 4,
   parameter int TOL         = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clki,
   input  logic             rst,
   input  logic             clkm,
   input  logic             clr,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {SEEK = 2'd0, TRACK = 2'd1, LOCK = 2'd2} state_t;

   localparam int               MW      = $clog2(LOCK_COUNT + 1);
   localparam int               CW1     = CNT_W + 1;
   localparam logic [MW-1:0]    LC      = MW'(LOCK_COUNT);
   localparam logic [CNT_W:0]   TOL_W   = CW1'(TOL);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               r_state, w_next_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                 r_prev;
   logic [CNT_W-1:0]     r_cnt, r_hcap, r_prev_per;
   logic [MW-1:0]        r_match_cnt;
   logic                 r_first;

   logic                 w_rise, w_fall, w_sat, w_match;
   logic [CNT_W:0]       w_diff, w_absdiff;
   logic [MW-1:0]        w_match_nxt;
   logic                 w_capture, w_match_clr, w_match_inc;
   logic                 w_lock_set, w_lock_clr, w_ovf_set;

   // Synchronizer plus one extra flop for edge detection.
   always_ff @(posedge clki or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], clkm};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_fall = ~r_sync[SYNC_STAGES-1] & r_prev;
   assign w_sat  = (r_cnt == CNT_MAX);

   // One extra bit keeps the sign, so |cnt - prev| never wraps.
   assign w_diff      = {1'b0, r_cnt} - {1'b0, r_prev_per};
   assign w_absdiff   = w_diff[CNT_W] ? ({CW1{1'b0}} - w_diff) : w_diff;
   assign w_match     = (w_absdiff <= TOL_W);
   assign w_match_nxt = r_match_cnt + MW'(1);

   always_ff @(posedge clki or posedge rst) begin
      if (rst) r_state <= SEEK;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_match_clr  = 1'b0;
      w_match_inc  = 1'b0;
      w_lock_set   = 1'b0;
      w_lock_clr   = 1'b0;
      w_ovf_set    = 1'b0;
      if (clr) begin
         w_next_state = SEEK;
      end else begin
         case (r_state)
            SEEK: begin
               if (w_rise) w_next_state = TRACK;
            end
            TRACK: begin
               if (w_rise) begin
                  w_capture = 1'b1;
                  if (r_first) begin
                     w_match_clr = 1'b1;
                  end else if (w_match) begin
                     w_match_inc = 1'b1;
                     if (w_match_nxt == LC) begin
                        w_lock_set   = 1'b1;
                        w_next_state = LOCK;
                     end
                  end else begin
                     w_match_clr = 1'b1;
                  end
               end else if (w_sat) begin
                  w_ovf_set    = 1'b1;
                  w_lock_clr   = 1'b1;
                  w_next_state = SEEK;
               end
            end
            LOCK: begin
               if (w_rise) begin
                  w_capture = 1'b1;
                  // A matching period keeps the lock; match_cnt simply holds.
                  if (!w_match) begin
                     w_lock_clr   = 1'b1;
                     w_match_clr  = 1'b1;
                     w_next_state = TRACK;
                  end
               end else if (w_sat) begin
                  w_ovf_set    = 1'b1;
                  w_lock_clr   = 1'b1;
                  w_next_state = SEEK;
               end
            end
            default: w_next_state = SEEK;
         endcase
      end
   end

   always_ff @(posedge clki or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_hcap      <= '0;
         r_prev_per  <= '0;
         r_match_cnt <= '0;
         r_first     <= 1'b0;
         period      <= '0;
         high_time   <= '0;
         valid       <= 1'b0;
         locked      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         // The counter keeps running through clr; only the measurement state is cleared.
         if (w_rise)      r_cnt <= CNT_W'(1);
         else if (!w_sat) r_cnt <= r_cnt + CNT_W'(1);

         if (w_rise)      r_hcap <= '0;
         else if (w_fall) r_hcap <= r_cnt;

         // The first measurement after SEEK has nothing to compare against.
         if (r_state == SEEK) r_first <= 1'b1;
         else if (w_capture)  r_first <= 1'b0;

         valid <= w_capture;

         if (clr) begin
            period      <= '0;
            high_time   <= '0;
            locked      <= 1'b0;
            overflow    <= 1'b0;
            r_match_cnt <= '0;
         end else begin
            if (w_capture) begin
               period     <= r_cnt;
               high_time  <= r_hcap;
               r_prev_per <= r_cnt;
            end
            if (w_match_clr)      r_match_cnt <= '0;
            else if (w_match_inc) r_match_cnt <= w_match_nxt;
            if (w_lock_set)       locked <= 1'b1;
            else if (w_lock_clr)  locked <= 1'b0;
            if (w_ovf_set)        overflow <= 1'b1;
         end
      end
   end

   assign dbg_state = r_state;

endmodule

// File: tb/tb_pll_div_monitor.sv
// tb_pll_div_monitor
//   Two monitors share one clkm waveform: dut_a has TOL=0 and dut_b has TOL=1,
//   both with CNT_W=8 and LOCK_COUNT=4. clkm changes only on clki negedges, so
//   each measurement is exact. The expected {period, high_time, locked} of every
//   valid comes from the high/low segment lengths the bench drives.
module tb_pll_div_monitor;

   localparam int W      = 8;
   localparam int LOCK_N = 4;
   localparam int EW     = 2 * W + 1;

   logic clki = 1'b0;
   logic rst, clkm, clr;
   logic [W-1:0] period_a, high_a, period_b, high_b;
   logic valid_a, locked_a, ovf_a, valid_b, locked_b, ovf_b;
   logic [1:0] st_a, st_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [EW-1:0] exp_a[$];
   logic [EW-1:0] exp_b[$];

   // Reference model state, described by clkm segments rather than by the
   // DUT's registers.
   bit m_seen;
   bit m_have;
   int m_prev, m_ph, m_pl;
   int m_run[2];

   typedef struct {
      int h;
      int l;
      int reps;
      int exp_per;
      int exp_high;
      bit exp_lock;
   } vec_t;
   vec_t tbl[4];

   pll_div_monitor #(.CNT_W(W), .LOCK_COUNT(LOCK_N), .TOL(0), .SYNC_STAGES(2)) dut_a (
      .clki(clki), .rst(rst), .clkm(clkm), .clr(clr),
      .period(period_a), .high_time(high_a), .valid(valid_a), .locked(locked_a),
      .overflow(ovf_a), .dbg_state(st_a)
   );

   pll_div_monitor #(.CNT_W(W), .LOCK_COUNT(LOCK_N), .TOL(1), .SYNC_STAGES(2)) dut_b (
      .clki(clki), .rst(rst), .clkm(clkm), .clr(clr),
      .period(period_b), .high_time(high_b), .valid(valid_b), .locked(locked_b),
      .overflow(ovf_b), .dbg_state(st_b)
   );

   always #5 clki = ~clki;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_seen   = 1'b0;
      m_have   = 1'b0;
      m_run[0] = 0;
      m_run[1] = 0;
   endfunction

   // Called when the bench starts a clkm high phase. Every rise after the
   // first one measures the previous segment.
   function automatic void model_rise(input int h, input int l);
      int meas, d, tol;
      logic lk;
      if (m_seen) begin
         meas = m_ph + m_pl;
         for (int k = 0; k < 2; k++) begin
            tol = (k == 0) ? 0 : 1;
            if (m_have) begin
               d = meas - m_prev;
               if (d < 0) d = -d;
               if (d <= tol) m_run[k]++;
               else          m_run[k] = 0;
            end
            lk = (m_run[k] >= LOCK_N);
            if (k == 0) exp_a.push_back({W'(meas), W'(m_ph), lk});
            else        exp_b.push_back({W'(meas), W'(m_ph), lk});
         end
         m_prev = meas;
         m_have = 1'b1;
      end
      m_seen = 1'b1;
      m_ph   = h;
      m_pl   = l;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clki);
   endtask

   task automatic drive_cycle(input int h, input int l);
      model_rise(h, l);
      clkm = 1'b1;
      idle(h);
      clkm = 1'b0;
      idle(l);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clki);
      clr = 1'b0;
      model_reset();
      idle(2);
   endtask

   task automatic chk_drained(input string name);
      chk({name, "_qa"}, 32'(exp_a.size()), 32'd0);
      chk({name, "_qb"}, 32'(exp_b.size()), 32'd0);
      exp_a.delete();
      exp_b.delete();
   endtask

   // Scoreboard: each valid must match the oldest expected measurement.
   always @(negedge clki) begin
      if (!rst) begin
         if (valid_a) begin
            if (exp_a.size() == 0) chk("unexpected_valid_a", 32'd1, 32'd0);
            else chk("meas_a", 32'({period_a, high_a, locked_a}), 32'(exp_a.pop_front()));
         end
         if (valid_b) begin
            if (exp_b.size() == 0) chk("unexpected_valid_b", 32'd1, 32'd0);
            else chk("meas_b", 32'({period_b, high_b, locked_b}), 32'(exp_b.pop_front()));
         end
      end
   end

   initial begin
      int h, l, reps;
      tbl[0] = '{h: 4, l: 4, reps: 8,  exp_per: 8,  exp_high: 4, exp_lock: 1'b1};
      tbl[1] = '{h: 3, l: 2, reps: 8,  exp_per: 5,  exp_high: 3, exp_lock: 1'b1};
      tbl[2] = '{h: 6, l: 6, reps: 5,  exp_per: 12, exp_high: 6, exp_lock: 1'b0};
      tbl[3] = '{h: 2, l: 2, reps: 10, exp_per: 4,  exp_high: 2, exp_lock: 1'b1};

      // Reset
      rst  = 1'b1;
      clr  = 1'b0;
      clkm = 1'b0;
      model_reset();
      idle(3);
      chk("rst_period", 32'(period_a), 32'd0);
      chk("rst_high",   32'(high_a),   32'd0);
      chk("rst_flags",  32'({valid_a, locked_a, ovf_a, valid_b, locked_b, ovf_b}), 32'd0);
      chk("rst_state",  32'({st_a, st_b}), 32'd0);
      rst = 1'b0;
      idle(3);

      // Directed ratio table
      for (int i = 0; i < 4; i++) begin
         pulse_clr();
         for (int r = 0; r < tbl[i].reps; r++) drive_cycle(tbl[i].h, tbl[i].l);
         idle(8);
         chk("tbl_period_a", 32'(period_a), 32'(tbl[i].exp_per));
         chk("tbl_high_a",   32'(high_a),   32'(tbl[i].exp_high));
         chk("tbl_lock_a",   32'(locked_a), 32'(tbl[i].exp_lock));
         chk("tbl_lock_b",   32'(locked_b), 32'(tbl[i].exp_lock));
         chk_drained("tbl");
      end

      // Ratio switch 8 -> 12 while locked
      pulse_clr();
      for (int r = 0; r < 8; r++) drive_cycle(4, 4);
      chk("sw_locked_before", 32'(locked_a), 32'd1);
      for (int r = 0; r < 6; r++) drive_cycle(6, 6);
      idle(8);
      chk("sw_relock",  32'(locked_a), 32'd1);
      chk("sw_period",  32'(period_a), 32'd12);
      chk_drained("sw");

      // Alternating 8/9: locks only with TOL=1
      pulse_clr();
      for (int r = 0; r < 12; r++) drive_cycle(4, (r % 2 == 1) ? 5 : 4);
      idle(8);
      chk("alt_lock_tol0", 32'(locked_a), 32'd0);
      chk("alt_lock_tol1", 32'(locked_b), 32'd1);
      chk_drained("alt");

      // Overflow: clkm held low while locked
      pulse_clr();
      for (int r = 0; r < 8; r++) drive_cycle(4, 4);
      idle(230);
      chk("ovf_early", 32'({ovf_a, ovf_b, locked_a}), 32'b001);
      idle(40);
      chk("ovf_set",    32'({ovf_a, ovf_b}), 32'b11);
      chk("ovf_unlock", 32'({locked_a, locked_b}), 32'b00);
      chk("ovf_state",  32'(st_a), 32'd0);
      model_reset();
      for (int r = 0; r < 8; r++) drive_cycle(4, 4);
      idle(8);
      chk("ovf_relock", 32'({locked_a, ovf_a}), 32'b11);
      chk_drained("ovf");
      pulse_clr();
      chk("ovf_clr", 32'({ovf_a, locked_a, period_a}), 32'd0);

      // Asynchronous reset while locked
      for (int r = 0; r < 8; r++) drive_cycle(4, 4);
      idle(3);
      chk("pre_arst_lock", 32'(locked_a), 32'd1);
      chk_drained("pre_arst");
      #2 rst = 1'b1;
      #1;
      chk("arst_outs",  32'({period_a, high_a}), 32'd0);
      chk("arst_flags", 32'({valid_a, locked_a, ovf_a, st_a}), 32'd0);
      @(negedge clki);
      rst = 1'b0;
      model_reset();
      idle(2);

      // clr in the same cycle as a detected rise
      for (int r = 0; r < 8; r++) drive_cycle(4, 4);
      clkm = 1'b1;
      idle(2);
      clr = 1'b1;
      @(negedge clki);
      clr = 1'b0;
      chk("clr_rise_state", 32'(st_a), 32'd0);
      chk("clr_rise_valid", 32'({valid_a, locked_a}), 32'd0);
      @(negedge clki);
      clkm = 1'b0;
      model_reset();
      idle(4);
      for (int r = 0; r < 6; r++) drive_cycle(4, 4);
      idle(8);
      chk("clr_rise_relock", 32'(locked_a), 32'd1);
      chk_drained("clr_rise");

      // Randomized segment groups
      pulse_clr();
      for (int g = 0; g < 20; g++) begin
         h    = $urandom_range(2, 7);
         l    = $urandom_range(2, 7);
         reps = $urandom_range(1, 7);
         for (int r = 0; r < reps; r++)
            drive_cycle(h + (($urandom_range(0, 3) == 0) ? 1 : 0), l);
      end
      idle(10);
      chk_drained("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
